// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART 8N1 receiver with a receive buffer behind a valid/ready pop port.
// Build option UART_RX_FIFO_EN: when defined, a FIFO_DEPTH-entry circular buffer;
// when undefined, a single holding register (FIFO_DEPTH ignored).
module uart_rx_fifo #(
  parameter int unsigned CLK_PER_BIT = 5,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rvalid,
  input  logic       rready,
  output logic       busy,
  output logic       ferr,
  output logic       overrun
);

  localparam int unsigned CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          rx_m, rx_s;
  logic          push_c, pop_c, full_c, wr_en_c;

  // Two-flop synchroniser; idles high so reset looks like a quiet line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rxd;
      rx_s <= rx_m;
    end
  end

  // A good stop bit is the push; a full buffer accepts it only if popping the same edge
  assign push_c  = (state == S_STOP) && (cnt == CNT_LAST) && rx_s;
  assign pop_c   = rvalid && rready;
  assign wr_en_c = push_c && (!full_c || pop_c);

  // Receiver FSM: half-bit start check, then mid-bit sampling of data and stop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      busy  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      ferr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= S_DATA;
              idx   <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_BREAK;
              ferr  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Overrun pulse: completed byte had nowhere to go
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overrun <= 1'b0;
    else      overrun <= push_c && full_c && !pop_c;
  end

`ifdef UART_RX_FIFO_EN
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_n;
  logic [AW:0]   count, count_n;
  logic [7:0]    head_n;

  assign full_c = (count == (AW+1)'(FIFO_DEPTH));

  // Next head pointer/count and the byte that will sit at the head after this edge
  always_comb begin
    rptr_n  = rptr + AW'(pop_c);
    count_n = count + (AW+1)'(wr_en_c) - (AW+1)'(pop_c);
    head_n  = mem[rptr_n];
    if (wr_en_c && (wptr == rptr_n)) head_n = shift;
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wptr] <= shift;
  end

  // Pointers, occupancy and registered head outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      if (wr_en_c) wptr <= wptr + AW'(1);
      rptr   <= rptr_n;
      count  <= count_n;
      rdata  <= head_n;
      rvalid <= (count_n != '0);
    end
  end
`else
  assign full_c = rvalid;

  // Single holding register; a push during a pop replaces the byte in place
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (wr_en_c) begin
      rdata  <= shift;
      rvalid <= 1'b1;
    end else if (pop_c) begin
      rvalid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frames driven bit by bit, bytes tracked in a queue model.
module tb_uart_rx_fifo;

  localparam int unsigned CPB = 5;
`ifdef UART_RX_FIFO_EN
  localparam int unsigned DEPTH = 4;
`else
  localparam int unsigned DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rready = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, busy, ferr, overrun;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rdata(rdata), .rvalid(rvalid),
    .rready(rready), .busy(busy), .ferr(ferr), .overrun(overrun)
  );

  // Drive one frame from a falling edge; returns at the negedge right after the stop sample.
  // pop_end raises rready for the final cycle so the pop coincides with the push.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit pop_end,
                            output logic [7:0] seen);
    seen = 8'h00;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB - 1) @(negedge clk);
    if (pop_end) begin
      seen   = rdata;
      rready = 1'b1;
    end
    @(negedge clk);
    rready = 1'b0;
    if (stop_bit) rxd = 1'b1;
  endtask

  // Pop everything the model holds, checking order, then confirm the buffer is empty
  task automatic drain(input string tag);
    logic [7:0] exp;
    while (q.size() > 0) begin
      exp = q.pop_front();
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== exp) begin
        n_err++;
        $display("FAIL %s_pop: got rvalid=%b rdata=%h, expected rvalid=1 rdata=%h",
                 tag, rvalid, rdata, exp);
      end
      rready = 1'b1;
      @(negedge clk);
    end
    rready = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_empty: got rvalid=%b, expected 0", tag, rvalid);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rdata, rvalid, busy, ferr, overrun} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got rdata=%h rvalid=%b busy=%b ferr=%b overrun=%b, expected all 0",
               rdata, rvalid, busy, ferr, overrun);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] s;
    send_frame(8'h03, 1'b1, 1'b0, s);
    q.push_back(8'h03);
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 8'h03 || ferr !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single: got rvalid=%b rdata=%h ferr=%b overrun=%b busy=%b, expected 1 03 0 0 0",
               rvalid, rdata, ferr, overrun, busy);
    end
    repeat (3) @(negedge clk);
    drain("single");
  endtask

  task automatic test_fill_overrun();
    logic [7:0] bytes [5] = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h55};
    logic [7:0] s;
    bit exp_ovr;
    for (int i = 0; i < 5; i++) begin
      exp_ovr = (q.size() >= DEPTH);
      send_frame(bytes[i], 1'b1, 1'b0, s);
      if (!exp_ovr) q.push_back(bytes[i]);
      n_cmp++;
      if (overrun !== exp_ovr || ferr !== 1'b0 || rvalid !== 1'b1 || rdata !== q[0]) begin
        n_err++;
        $display("FAIL fill_frame%0d: got overrun=%b ferr=%b rvalid=%b rdata=%h, expected %b 0 1 %h",
                 i, overrun, ferr, rvalid, rdata, exp_ovr, q[0]);
      end
      @(negedge clk);
      n_cmp++;
      if (overrun !== 1'b0) begin
        n_err++;
        $display("FAIL fill_pulse%0d: got overrun=%b one cycle later, expected 0", i, overrun);
      end
    end
    drain("fill");
  endtask

  task automatic test_glitch();
    bit saw_busy = 0;
    bit bad = 0;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (busy) saw_busy = 1;
      if (rvalid || ferr) bad = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_busy !== 1'b1 || bad !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL glitch: got saw_busy=%b rvalid_or_ferr=%b busy_end=%b, expected 1 0 0",
               saw_busy, bad, busy);
    end
  endtask

  task automatic test_ferr();
    logic [7:0] s;
    bit bad = 0;
    int waited = 0;
    send_frame(8'hA5, 1'b0, 1'b0, s);
    n_cmp++;
    if (ferr !== 1'b1 || rvalid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL ferr_flag: got ferr=%b rvalid=%b busy=%b, expected 1 0 1", ferr, rvalid, busy);
    end
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (ferr || rvalid || !busy) bad = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL ferr_hold: got ferr/rvalid/idle during break=%b, expected 0", bad);
    end
    rxd = 1'b1;
    while (busy === 1'b1 && waited < 10) begin
      waited++;
      @(negedge clk);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL ferr_release: got busy=%b after %0d cycles of idle line, expected 0", busy, waited);
    end
    @(negedge clk);
    send_frame(8'h3C, 1'b1, 1'b0, s);
    q.push_back(8'h3C);
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 8'h3C || ferr !== 1'b0) begin
      n_err++;
      $display("FAIL ferr_next: got rvalid=%b rdata=%h ferr=%b, expected 1 3c 0", rvalid, rdata, ferr);
    end
    drain("ferr");
  endtask

  task automatic test_midreset();
    logic [7:0] s;
    logic [7:0] b;
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b0, s);
    q.push_back(b);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rxd = b[i];
      repeat ((i == 4) ? 2 : CPB) @(negedge clk);
    end
    rst = 1'b0;
    #1;
    q.delete();
    n_cmp++;
    if ({rdata, rvalid, busy, ferr, overrun} !== 12'h000) begin
      n_err++;
      $display("FAIL midreset: got rdata=%h rvalid=%b busy=%b ferr=%b overrun=%b, expected all 0",
               rdata, rvalid, busy, ferr, overrun);
    end
    @(negedge clk);
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0, s);
    q.push_back(8'h81);
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 8'h81) begin
      n_err++;
      $display("FAIL midreset_next: got rvalid=%b rdata=%h, expected 1 81", rvalid, rdata);
    end
    drain("midreset");
  endtask

  // Fill to capacity, then complete a frame on the same edge as a pop
  task automatic test_push_pop();
    logic [7:0] s;
    logic [7:0] b;
    for (int i = 0; i < int'(DEPTH); i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0, s);
      q.push_back(b);
      @(negedge clk);
    end
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b1, s);
    n_cmp++;
    if (s !== q[0]) begin
      n_err++;
      $display("FAIL pushpop_head: got rdata=%h at pop, expected %h", s, q[0]);
    end
    void'(q.pop_front());
    q.push_back(b);
    n_cmp++;
    if (overrun !== 1'b0 || rvalid !== 1'b1 || rdata !== q[0]) begin
      n_err++;
      $display("FAIL pushpop_after: got overrun=%b rvalid=%b rdata=%h, expected 0 1 %h",
               overrun, rvalid, rdata, q[0]);
    end
    drain("pushpop");
  endtask

  task automatic test_random();
    logic [7:0] s;
    logic [7:0] b;
    bit pe, exp_ovr;
    int n;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, DEPTH + 2));
      for (int k = 0; k < n; k++) begin
        b  = 8'($urandom);
        pe = 1'($urandom_range(0, 1));
        send_frame(b, 1'b1, pe, s);
        if (pe && q.size() > 0) begin
          n_cmp++;
          if (s !== q[0]) begin
            n_err++;
            $display("FAIL rand%0d_%0d_head: got %h, expected %h", it, k, s, q[0]);
          end
          void'(q.pop_front());
        end
        exp_ovr = (q.size() >= DEPTH);
        if (!exp_ovr) q.push_back(b);
        n_cmp++;
        if (overrun !== exp_ovr || rvalid !== 1'b1 || rdata !== q[0]) begin
          n_err++;
          $display("FAIL rand%0d_%0d: got overrun=%b rvalid=%b rdata=%h, expected %b 1 %h",
                   it, k, overrun, rvalid, rdata, exp_ovr, q[0]);
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drain("rand");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overrun();
    test_glitch();
    test_ferr();
    test_midreset();
    test_push_pop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
